// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types, opcodes, ALU codes and per-state control table for the multicycle control unit
package mcu_pkg;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9, BEQ = 4'd10, TRAP = 4'd11
  } state_t;
  typedef enum logic [1:0] {ADD, SUB, FUNCT} aluop_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_SLT = 3'b101;
  // fetch: IRWrite/PCWrite follow mem_ready; branch: PCWrite follows Zero
  typedef struct packed {
    logic fetch, pcw, branch, memw, regw, adr;
    logic [1:0] res, srca, srcb;
    aluop_t aluop;
  } ctrl_t;
  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.fetch = 1'b1; c.res = 2'b10; c.srcb = 2'b10; end
      DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
      MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
      MEMREAD:  c.adr = 1'b1;
      MEMWB:    begin c.res = 2'b01; c.regw = 1'b1; end
      MEMWRITE: begin c.adr = 1'b1; c.memw = 1'b1; end
      EXECR:    begin c.srca = 2'b10; c.aluop = FUNCT; end
      EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = FUNCT; end
      ALUWB:    c.regw = 1'b1;
      JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1'b1; end
      BEQ:      begin c.srca = 2'b10; c.branch = 1'b1; c.aluop = SUB; end
      default:  ;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/mcu_alu_decoder.sv
// mcu_alu_decoder: maps ALUOp/funct3/funct7b5 to a zero-extended ALUControl code
// Ports: i_aluop (add/sub/funct), i_funct3, i_op5 (opcode bit 5), i_funct7b5 -> o_alu_control
module mcu_alu_decoder
  import mcu_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_t               i_aluop,
  input  logic [2:0]           i_funct3,
  input  logic                 i_op5,
  input  logic                 i_funct7b5,
  output logic [ALUCTRL_W-1:0] o_alu_control
);
  logic [2:0] w_funct, w_code;
  always_comb begin
    w_funct = i_funct3 == 3'b000 ? ((i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD) :
              i_funct3 == 3'b010 ? ALU_SLT :
              i_funct3 == 3'b110 ? ALU_OR  :
              i_funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    w_code  = i_aluop == SUB ? ALU_SUB : i_aluop == FUNCT ? w_funct : ALU_ADD;
  end
  assign o_alu_control = ALUCTRL_W'(w_code);
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing RV32I instructions with a memory-ready stall handshake
// Ports: clk, rst_n (sync, active low); op/funct3/funct7b5 from the IR; Zero from the ALU;
//   mem_ready memory handshake; PCWrite/AdrSrc/MemWrite/IRWrite/RegWrite/ResultSrc/ALUSrcA/ALUSrcB/
//   ImmSrc/ALUControl datapath controls; state_o debug state.
// Macro MCU_ILLEGAL_TRAP_EN: illegal opcodes park in TRAP and raise illegal_instr; otherwise they act as NOPs.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter bit HAS_MEM_READY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           state_o
`ifdef MCU_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_instr
`endif
);
`ifdef MCU_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = TRAP;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif
  state_t               r_state, w_next;
  ctrl_t                r_ctrl;
  logic                 w_rdy;
  logic [1:0]           w_imm;
  logic [ALUCTRL_W-1:0] w_aluc;
  assign w_rdy = !HAS_MEM_READY || mem_ready;
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = w_rdy ? DECODE : FETCH;
      DECODE:   w_next = (op == OP_LW || op == OP_SW) ? MEMADR :
                         op == OP_R ? EXECR : op == OP_I ? EXECI :
                         op == OP_JAL ? JAL : op == OP_BEQ ? BEQ : ILLEGAL_NEXT;
      MEMADR:   w_next = op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = w_rdy ? MEMWB : MEMREAD;
      MEMWRITE: w_next = w_rdy ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: w_next = ALUWB;
      TRAP:     w_next = TRAP;
      default:  w_next = FETCH;
    endcase
    w_imm = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
  end
  // control fields are registered alongside the state; only the handshake/Zero terms stay combinational
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_ctrl  <= ctrl_of(FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next);
    end
  end
  mcu_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .i_aluop(r_ctrl.aluop), .i_funct3(funct3), .i_op5(op[5]), .i_funct7b5(funct7b5),
    .o_alu_control(w_aluc)
  );
  assign PCWrite    = rst_n && (r_ctrl.pcw || (r_ctrl.fetch && w_rdy) || (r_ctrl.branch && Zero));
  assign IRWrite    = rst_n && r_ctrl.fetch && w_rdy;
  assign MemWrite   = rst_n && r_ctrl.memw;
  assign RegWrite   = rst_n && r_ctrl.regw;
  assign AdrSrc     = rst_n && r_ctrl.adr;
  assign ResultSrc  = rst_n ? r_ctrl.res : 2'b00;
  assign ALUSrcA    = rst_n ? r_ctrl.srca : 2'b00;
  assign ALUSrcB    = rst_n ? r_ctrl.srcb : 2'b00;
  assign ImmSrc     = rst_n ? w_imm : 2'b00;
  assign ALUControl = rst_n ? w_aluc : '0;
  assign state_o    = r_state;
`ifdef MCU_ILLEGAL_TRAP_EN
  assign illegal_instr = r_state == TRAP;
`endif
endmodule
